// File: rtl/core_pkg.sv
// Shared front-end types: PC width, instruction width and the fetch-buffer entry.
package core_pkg;
  localparam int XLEN = 32;
  localparam int ILEN = 32;
  localparam logic [ILEN-1:0] NOP = 32'h0000_0013;

  typedef struct packed {
    logic [ILEN-1:0] inst;
    logic [XLEN-1:0] pc;
  } fetch_entry_t;
endpackage

// File: rtl/fetch_fifo.sv
// Prefetch buffer: DEPTH-entry synchronous FIFO of fetch entries with flush.
// Flush wins over push and pop in the same cycle.
module fetch_fifo
  import core_pkg::*;
#(
  parameter int DEPTH = 2
) (
  input  logic                           clk,
  input  logic                           reset,
  input  logic                           flush,
  input  logic                           push,
  input  fetch_entry_t                   push_data,
  input  logic                           pop,
  output fetch_entry_t                   head,
  output logic                           empty,
  output logic [$clog2(DEPTH+1)-1:0]     count
);
  localparam int CW = $clog2(DEPTH + 1);
  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  fetch_entry_t  mem [DEPTH];
  logic [AW-1:0] rd_ptr;
  logic [AW-1:0] wr_ptr;
  logic          full;
  logic          do_push;
  logic          do_pop;

  function automatic logic [AW-1:0] bump(input logic [AW-1:0] p);
    return (p == AW'(DEPTH - 1)) ? '0 : p + AW'(1);
  endfunction

  assign empty   = (count == '0);
  assign full    = (count == CW'(DEPTH));
  assign do_pop  = pop && !empty;
  // A full FIFO still accepts a push when the head leaves in the same cycle.
  assign do_push = push && (!full || do_pop);
  assign head    = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (reset || flush) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= bump(wr_ptr);
      if (do_pop)  rd_ptr <= bump(rd_ptr);
      count <= count + CW'(do_push) - CW'(do_pop);
    end
  end

  always_ff @(posedge clk) begin
    if (!reset && !flush && do_push) mem[wr_ptr] <= push_data;
  end
endmodule

// File: rtl/instruction_fetch.sv
// Fetch stage: PC, credit-limited imem requests, prefetch FIFO and redirect flush.
// Optional build macro FETCH_MISALIGN_CHECK_EN enables the misaligned-redirect fault.
module instruction_fetch #(
  parameter int              XLEN      = 32,
  parameter logic [XLEN-1:0] BOOT_ADDR = '0,
  parameter int              DEPTH     = 2
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            redirect_valid,
  input  logic [XLEN-1:0] redirect_pc,
  output logic            imem_req,
  output logic [XLEN-1:0] imem_addr,
  input  logic            imem_gnt,
  input  logic            imem_rvalid,
  input  logic [31:0]     imem_rdata,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [31:0]     out_inst,
  output logic [XLEN-1:0] out_pc,
  output logic            fetch_fault
);
  import core_pkg::*;

  localparam int CW = $clog2(DEPTH + 1);

  // Handshakes: imem transfers on a rising edge with imem_req && imem_gnt, and req/addr
  // stay put until then; decode transfers on out_valid && out_ready, out_* stable until taken.
  logic [XLEN-1:0] fetch_pc;
  logic [XLEN-1:0] resp_pc;
  logic [XLEN-1:0] target_pc;
  logic [CW-1:0]   outstanding;
  logic [CW-1:0]   discard;
  logic [CW-1:0]   fifo_count;
  logic            fetch_blocked;
  logic            credit_ok;
  logic            fire;
  logic            push;
  logic            fifo_empty;
  fetch_entry_t    push_entry;
  fetch_entry_t    head;

`ifdef FETCH_MISALIGN_CHECK_EN
  logic fault_q;

  assign target_pc = redirect_pc;

  always_ff @(posedge clk) begin
    if (reset)               fault_q <= 1'b0;
    else if (redirect_valid) fault_q <= |redirect_pc[1:0];
  end

  assign fetch_blocked = fault_q;
  assign fetch_fault   = fault_q;
`else
  logic unused_redirect_lsbs;

  assign unused_redirect_lsbs = ^redirect_pc[1:0];
  assign target_pc            = {redirect_pc[XLEN-1:2], 2'b00};
  assign fetch_blocked        = 1'b0;
  assign fetch_fault          = 1'b0;
`endif

  // Buffered plus in-flight never exceeds DEPTH, so every response has a slot.
  assign credit_ok = ({1'b0, fifo_count} + {1'b0, outstanding}) < (CW + 1)'(DEPTH);
  assign imem_req  = !reset && !redirect_valid && !fetch_blocked && credit_ok;
  assign imem_addr = fetch_pc;
  assign fire      = imem_req && imem_gnt;
  assign push      = !reset && !redirect_valid && imem_rvalid && (discard == '0);

  assign push_entry.inst = imem_rdata;
  assign push_entry.pc   = resp_pc;

  always_ff @(posedge clk) begin
    if (reset) begin
      fetch_pc    <= BOOT_ADDR;
      resp_pc     <= BOOT_ADDR;
      outstanding <= '0;
      discard     <= '0;
    end else if (redirect_valid) begin
      // Everything still in flight after this cycle belongs to the old path.
      fetch_pc    <= target_pc;
      resp_pc     <= target_pc;
      outstanding <= outstanding - CW'(imem_rvalid);
      discard     <= outstanding - CW'(imem_rvalid);
    end else begin
      if (fire) fetch_pc <= fetch_pc + XLEN'(4);
      if (push) resp_pc  <= resp_pc + XLEN'(4);
      outstanding <= outstanding + CW'(fire) - CW'(imem_rvalid);
      if (imem_rvalid && (discard != '0)) discard <= discard - CW'(1);
    end
  end

  fetch_fifo #(
    .DEPTH(DEPTH)
  ) u_fifo (
    .clk       (clk),
    .reset     (reset),
    .flush     (redirect_valid),
    .push      (push),
    .push_data (push_entry),
    .pop       (out_valid && out_ready),
    .head      (head),
    .empty     (fifo_empty),
    .count     (fifo_count)
  );

  assign out_valid = !fifo_empty;
  assign out_inst  = out_valid ? head.inst : '0;
  assign out_pc    = out_valid ? head.pc   : '0;
endmodule

// File: tb/tb_instruction_fetch.sv
// Bench for instruction_fetch: randomized in-order memory model and an expected-PC scoreboard.
// Build with FETCH_MISALIGN_CHECK_EN to exercise the misaligned-redirect fault path.
module tb_instruction_fetch;
  localparam int          XLEN  = 32;
  localparam int          DEPTH = 2;
  localparam logic [31:0] BOOT  = 32'h0000_0000;

  logic              clk = 1'b0;
  logic              reset = 1'b1;
  logic              redirect_valid = 1'b0;
  logic [XLEN-1:0]   redirect_pc = '0;
  logic              imem_req;
  logic [XLEN-1:0]   imem_addr;
  logic              imem_gnt;
  logic              imem_rvalid;
  logic [31:0]       imem_rdata;
  logic              out_valid;
  logic              out_ready = 1'b1;
  logic [31:0]       out_inst;
  logic [XLEN-1:0]   out_pc;
  logic              fetch_fault;

  int n_checks = 0;
  int n_pass   = 0;
  int cyc      = 0;
  int gnt_pct  = 100;
  int lat_min  = 1;
  int lat_max  = 1;
  int last_due = 0;
  logic [31:0] rq_addr[$];
  int          rq_due[$];
  logic [31:0] exp_q[$];

  instruction_fetch #(
    .XLEN      (XLEN),
    .BOOT_ADDR (BOOT),
    .DEPTH     (DEPTH)
  ) dut (
    .clk            (clk),
    .reset          (reset),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .imem_req       (imem_req),
    .imem_addr      (imem_addr),
    .imem_gnt       (imem_gnt),
    .imem_rvalid    (imem_rvalid),
    .imem_rdata     (imem_rdata),
    .out_valid      (out_valid),
    .out_ready      (out_ready),
    .out_inst       (out_inst),
    .out_pc         (out_pc),
    .fetch_fault    (fetch_fault)
  );

  // Clock and watchdog
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, checks %0d/%0d", n_pass, n_checks);
    $fatal(1);
  end

  // Golden instruction memory contents
  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return (a * 32'h9E37_79B1) ^ 32'h1357_9BDF;
  endfunction

  // Expected in-order PC stream of the current path
  task automatic expect_path(input logic [31:0] start);
    exp_q.delete();
    for (int i = 0; i < 256; i++) exp_q.push_back(start + 32'(4 * i));
  endtask

  // Memory model: random grant, in-order responses 1..N cycles after the grant
  initial begin
    int due;
    imem_gnt = 1'b0;
    imem_rvalid = 1'b0;
    imem_rdata = '0;
    forever begin
      @(negedge clk);
      #1;
      if (reset) begin
        rq_addr.delete();
        rq_due.delete();
        last_due = cyc;
        imem_gnt = 1'b0;
        imem_rvalid = 1'b0;
      end else begin
        imem_gnt = ($urandom_range(99) < gnt_pct);
        if (rq_due.size() > 0 && rq_due[0] <= cyc) begin
          imem_rvalid = 1'b1;
          imem_rdata = mem_word(rq_addr[0]);
        end else begin
          imem_rvalid = 1'b0;
          imem_rdata = $urandom;
        end
      end
      #2;
      if (!reset) begin
        if (imem_rvalid) begin
          void'(rq_addr.pop_front());
          void'(rq_due.pop_front());
        end
        if (imem_req && imem_gnt) begin
          due = cyc + int'($urandom_range(lat_max, lat_min));
          if (due <= last_due) due = last_due + 1;
          last_due = due;
          rq_addr.push_back(imem_addr);
          rq_due.push_back(due);
        end
      end
      cyc++;
    end
  end

  // Driver: apply inputs just after the falling edge, leave outputs to settle before sampling
  task automatic drive(input logic rst, input logic rdy, input logic rv, input logic [31:0] rpc);
    @(negedge clk);
    reset = rst;
    out_ready = rdy;
    redirect_valid = rv;
    redirect_pc = rpc;
    #4;
  endtask

  task automatic test_reset();
    for (int i = 0; i < 3; i++) drive(1'b1, 1'b1, 1'b0, 32'h0);
    n_checks++;
    if (imem_req !== 1'b0) $display("FAIL reset_req: got %b want 0", imem_req); else n_pass++;
    n_checks++;
    if (out_valid !== 1'b0) $display("FAIL reset_valid: got %b want 0", out_valid); else n_pass++;
    n_checks++;
    if (out_inst !== 32'h0) $display("FAIL reset_inst: got %h want 0", out_inst); else n_pass++;
    n_checks++;
    if (out_pc !== 32'h0) $display("FAIL reset_pc: got %h want 0", out_pc); else n_pass++;
    n_checks++;
    if (fetch_fault !== 1'b0) $display("FAIL reset_fault: got %b want 0", fetch_fault); else n_pass++;
  endtask

  task automatic test_sequential();
    int first_valid = -1;
    int fires = 0;
    int pops = 0;
    logic [31:0] e;
    gnt_pct = 100; lat_min = 1; lat_max = 1;
    expect_path(BOOT);
    for (int i = 0; i < 24; i++) begin
      drive(1'b0, 1'b1, 1'b0, 32'h0);
      if (out_valid && first_valid < 0) first_valid = i;
      if (imem_req && imem_gnt) begin
        n_checks++;
        if (imem_addr !== BOOT + 32'(4 * fires))
          $display("FAIL seq_addr: got %h want %h", imem_addr, BOOT + 32'(4 * fires));
        else n_pass++;
        fires++;
      end
      if (out_valid && out_ready) begin
        e = exp_q.pop_front();
        n_checks++;
        if (out_pc !== e || out_inst !== mem_word(e))
          $display("FAIL seq_stream: pc=%h inst=%h want pc=%h inst=%h", out_pc, out_inst, e, mem_word(e));
        else n_pass++;
        pops++;
      end
    end
    // Cycle 0 is the first with reset low: grant in 0, response in 1, visible in 2.
    n_checks++;
    if (first_valid != 2) $display("FAIL seq_latency: first out_valid cycle %0d want 2", first_valid);
    else n_pass++;
    n_checks++;
    if (pops < 8) $display("FAIL seq_count: %0d outputs want >= 8", pops); else n_pass++;
  endtask

  task automatic test_stall();
    int run = 0;
    bit in_run = 1'b1;
    logic [31:0] e;
    for (int i = 0; i < 10; i++) drive(1'b0, 1'b0, 1'b0, 32'h0);
    n_checks++;
    if (imem_req !== 1'b0) $display("FAIL stall_req: got %b want 0", imem_req); else n_pass++;
    n_checks++;
    if (out_valid !== 1'b1) $display("FAIL stall_valid: got %b want 1", out_valid); else n_pass++;
    n_checks++;
    if (rq_addr.size() != 0) $display("FAIL stall_inflight: %0d in flight want 0", rq_addr.size());
    else n_pass++;
    for (int i = 0; i < 14; i++) begin
      drive(1'b0, 1'b1, 1'b0, 32'h0);
      if (in_run && out_valid) run++; else in_run = 1'b0;
      if (out_valid && out_ready) begin
        e = exp_q.pop_front();
        n_checks++;
        if (out_pc !== e || out_inst !== mem_word(e))
          $display("FAIL stall_stream: pc=%h inst=%h want pc=%h inst=%h", out_pc, out_inst, e, mem_word(e));
        else n_pass++;
      end
    end
    n_checks++;
    if (run != DEPTH) $display("FAIL stall_buffered: %0d back-to-back outputs want %0d", run, DEPTH);
    else n_pass++;
  endtask

  task automatic test_random();
    int pops = 0;
    logic prev_req = 1'b0;
    logic prev_gnt = 1'b0;
    logic [31:0] prev_addr = '0;
    logic [31:0] e;
    gnt_pct = 50; lat_min = 1; lat_max = 3;
    for (int i = 0; i < 400; i++) begin
      drive(1'b0, ($urandom_range(9) < 7), 1'b0, 32'h0);
      if (prev_req && !prev_gnt) begin
        n_checks++;
        if (imem_req !== 1'b1 || imem_addr !== prev_addr)
          $display("FAIL rand_hold: req=%b addr=%h want req=1 addr=%h", imem_req, imem_addr, prev_addr);
        else n_pass++;
      end
      prev_req = imem_req; prev_gnt = imem_gnt; prev_addr = imem_addr;
      if (out_valid && out_ready) begin
        e = exp_q.pop_front();
        n_checks++;
        if (out_pc !== e || out_inst !== mem_word(e))
          $display("FAIL rand_stream: pc=%h inst=%h want pc=%h inst=%h", out_pc, out_inst, e, mem_word(e));
        else n_pass++;
        pops++;
      end
    end
    n_checks++;
    if (pops < 40) $display("FAIL rand_count: %0d outputs want >= 40", pops); else n_pass++;
  endtask

  task automatic test_redirect();
    bit found = 1'b0;
    bit first = 1'b1;
    int pops = 0;
    logic [31:0] e;
    gnt_pct = 100; lat_min = 3; lat_max = 3;
    for (int i = 0; i < 40 && !found; i++) begin
      drive(1'b0, 1'b1, 1'b0, 32'h0);
      if (out_valid && out_ready) begin
        e = exp_q.pop_front();
        n_checks++;
        if (out_pc !== e || out_inst !== mem_word(e))
          $display("FAIL redir_pre_stream: pc=%h inst=%h want pc=%h inst=%h", out_pc, out_inst, e, mem_word(e));
        else n_pass++;
      end
      if (rq_addr.size() == 2) found = 1'b1;
    end
    n_checks++;
    if (!found) $display("FAIL redir_setup: %0d in flight want 2", rq_addr.size()); else n_pass++;
    drive(1'b0, 1'b1, 1'b1, 32'h100);
    n_checks++;
    if (imem_req !== 1'b0) $display("FAIL redir_req: got %b want 0", imem_req); else n_pass++;
    expect_path(32'h100);
    for (int i = 0; i < 30; i++) begin
      drive(1'b0, 1'b1, 1'b0, 32'h0);
      if (out_valid && out_ready) begin
        e = exp_q.pop_front();
        if (first) begin
          n_checks++;
          if (out_pc !== 32'h100) $display("FAIL redir_first: pc=%h want 00000100", out_pc); else n_pass++;
          first = 1'b0;
        end
        n_checks++;
        if (out_pc !== e || out_inst !== mem_word(e))
          $display("FAIL redir_stream: pc=%h inst=%h want pc=%h inst=%h", out_pc, out_inst, e, mem_word(e));
        else n_pass++;
        pops++;
      end
    end
    n_checks++;
    if (pops < 5) $display("FAIL redir_count: %0d outputs want >= 5", pops); else n_pass++;
  endtask

  task automatic test_back_to_back();
    int pops = 0;
    logic [31:0] e;
    gnt_pct = 100; lat_min = 1; lat_max = 1;
    for (int i = 0; i < 6; i++) begin
      drive(1'b0, 1'b1, 1'b0, 32'h0);
      if (out_valid && out_ready) begin
        e = exp_q.pop_front();
        n_checks++;
        if (out_pc !== e || out_inst !== mem_word(e))
          $display("FAIL b2b_pre_stream: pc=%h inst=%h want pc=%h inst=%h", out_pc, out_inst, e, mem_word(e));
        else n_pass++;
      end
    end
    drive(1'b0, 1'b1, 1'b1, 32'h200);
    drive(1'b0, 1'b1, 1'b1, 32'h300);
    n_checks++;
    if (out_valid !== 1'b0) $display("FAIL b2b_flush: out_valid=%b want 0", out_valid); else n_pass++;
    expect_path(32'h300);
    drive(1'b0, 1'b1, 1'b0, 32'h0);
    n_checks++;
    if (imem_req !== 1'b1 || imem_addr !== 32'h300)
      $display("FAIL b2b_first_req: req=%b addr=%h want req=1 addr=00000300", imem_req, imem_addr);
    else n_pass++;
    n_checks++;
    if (out_valid !== 1'b0) $display("FAIL b2b_t1_valid: got %b want 0", out_valid); else n_pass++;
    drive(1'b0, 1'b1, 1'b0, 32'h0);
    n_checks++;
    if (out_valid !== 1'b0) $display("FAIL b2b_t2_valid: got %b want 0", out_valid); else n_pass++;
    for (int i = 0; i < 20; i++) begin
      drive(1'b0, 1'b1, 1'b0, 32'h0);
      if (i == 0) begin
        n_checks++;
        if (out_valid !== 1'b1 || out_pc !== 32'h300)
          $display("FAIL b2b_t3_out: valid=%b pc=%h want valid=1 pc=00000300", out_valid, out_pc);
        else n_pass++;
      end
      if (out_valid && out_ready) begin
        e = exp_q.pop_front();
        n_checks++;
        if (out_pc !== e || out_inst !== mem_word(e))
          $display("FAIL b2b_stream: pc=%h inst=%h want pc=%h inst=%h", out_pc, out_inst, e, mem_word(e));
        else n_pass++;
        pops++;
      end
    end
    n_checks++;
    if (pops < 8) $display("FAIL b2b_count: %0d outputs want >= 8", pops); else n_pass++;
  endtask

  task automatic test_misalign();
    int pops = 0;
    logic [31:0] e;
    gnt_pct = 100; lat_min = 1; lat_max = 1;
    drive(1'b0, 1'b1, 1'b1, 32'h102);
`ifdef FETCH_MISALIGN_CHECK_EN
    exp_q.delete();
    for (int i = 0; i < 6; i++) begin
      drive(1'b0, 1'b1, 1'b0, 32'h0);
      n_checks++;
      if (fetch_fault !== 1'b1 || imem_req !== 1'b0 || out_valid !== 1'b0)
        $display("FAIL mis_blocked: fault=%b req=%b valid=%b want 1/0/0", fetch_fault, imem_req, out_valid);
      else n_pass++;
    end
    drive(1'b0, 1'b1, 1'b1, 32'h400);
    expect_path(32'h400);
    for (int i = 0; i < 15; i++) begin
      drive(1'b0, 1'b1, 1'b0, 32'h0);
      if (i == 0) begin
        n_checks++;
        if (fetch_fault !== 1'b0 || imem_req !== 1'b1 || imem_addr !== 32'h400)
          $display("FAIL mis_resume: fault=%b req=%b addr=%h want 0/1/00000400", fetch_fault, imem_req, imem_addr);
        else n_pass++;
      end
`else
    expect_path(32'h100);
    for (int i = 0; i < 15; i++) begin
      drive(1'b0, 1'b1, 1'b0, 32'h0);
      if (i == 0) begin
        n_checks++;
        if (fetch_fault !== 1'b0 || imem_req !== 1'b1 || imem_addr !== 32'h100)
          $display("FAIL mis_align: fault=%b req=%b addr=%h want 0/1/00000100", fetch_fault, imem_req, imem_addr);
        else n_pass++;
      end
`endif
      if (out_valid && out_ready) begin
        e = exp_q.pop_front();
        n_checks++;
        if (out_pc !== e || out_inst !== mem_word(e))
          $display("FAIL mis_stream: pc=%h inst=%h want pc=%h inst=%h", out_pc, out_inst, e, mem_word(e));
        else n_pass++;
        pops++;
      end
    end
    n_checks++;
    if (pops < 4) $display("FAIL mis_count: %0d outputs want >= 4", pops); else n_pass++;
  endtask

  initial begin
    test_reset();
    test_sequential();
    test_stall();
    test_random();
    test_redirect();
    test_back_to_back();
    test_misalign();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
